// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 tables, GF(2^8) helpers and key-schedule steps
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int i);
    return blk[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5; 8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0; 8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc; 8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a; 8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0; 8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b; 8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85; 8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5; 8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17; 8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88; 8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c; 8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9; 8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6; 8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e; 8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94; 8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68; 8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38; 8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87; 8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d; 8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2; 8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16; 8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda; 8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a; 8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02; 8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea; 8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85; 8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89; 8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20; 8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31; 8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d; 8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0; 8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26; 8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;  4'd4: return 8'h08;
      4'd5: return 8'h10;  4'd6: return 8'h20;  4'd7: return 8'h40;  4'd8: return 8'h80;
      4'd9: return 8'h1b;  4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the InvMixColumns coefficients are needed: 9, 11, 13, 14.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (m)
      4'd9:    return x8 ^ b;
      4'd11:   return x8 ^ x2 ^ b;
      4'd13:   return x8 ^ x4 ^ b;
      4'd14:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: rebuild w0..w3 from w4..w7.
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round; last skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_out
);

  logic [127:0] sr;
  logic [127:0] ak;
  logic [127:0] mc;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    // Byte index is 4*col + row; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(st_in, 4*((c - r + 4) % 4) + r));
      end
    end
    ak = sr ^ rk;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(ak, 4*c);
      a1 = get_byte(ak, 4*c+1);
      a2 = get_byte(ak, 4*c+2);
      a3 = get_byte(ak, 4*c+3);
      mc[127-32*c -: 8]  = gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
      mc[119-32*c -: 8]  = gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
      mc[111-32*c -: 8]  = gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
      mc[103-32*c -: 8]  = gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
    end
  end

  assign st_out = last ? ak : mc;

endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 inverse cipher, one round per clock, key schedule on the fly
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         finish,
  output logic [127:0] out
);

  state_t       state, state_d;
  logic [3:0]   cnt;
  logic [127:0] ct_q;
  logic [127:0] rk;
  logic [127:0] st;
  logic [127:0] rnd_out;
  logic         last;

  // In ROUND, cnt is the index of the round key currently held in rk.
  assign last = (cnt == 4'd0);

  aes_inv_round u_round (
    .st_in  (st),
    .rk     (rk),
    .last   (last),
    .st_out (rnd_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = KEYEXP;
      KEYEXP:  if (!start) state_d = IDLE;
               else if (cnt == 4'd10) state_d = INIT;
      INIT:    state_d = start ? ROUND : IDLE;
      ROUND:   if (!start) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      ct_q   <= '0;
      rk     <= '0;
      st     <= '0;
      out    <= '0;
      finish <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ct_q <= in;
          rk   <= key;
          cnt  <= 4'd1;
        end
        KEYEXP: if (start) begin
          rk  <= key_fwd(rk, rcon(cnt));
          cnt <= cnt + 4'd1;
        end
        INIT: if (start) begin
          st  <= ct_q ^ rk;
          rk  <= key_inv(rk, rcon(4'd10));
          cnt <= 4'd9;
        end
        ROUND: if (start) begin
          if (last) begin
            out    <= rnd_out;
            finish <= 1'b1;
          end else begin
            st  <= rnd_out;
            rk  <= key_inv(rk, rcon(cnt));
            cnt <= cnt - 4'd1;
          end
        end
        DONE: if (!start) finish <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - self-checking bench for aes_decrypt against a table-driven InvCipher model
module tb_aes_decrypt;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic [127:0] dkey;
  logic         finish;
  logic [127:0] out;

  int total;
  int bad;

  logic [7:0] tsb  [256];
  logic [7:0] tisb [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (din),
    .key    (dkey),
    .finish (finish),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables;
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      tsb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) tisb[tsb[x]] = x[7:0];
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tsb[tmp[23:16]], tsb[tmp[15:8]], tsb[tmp[7:0]], tsb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
    for (int rnd = 10; rnd >= 0; rnd--) begin
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = tisb[s[4*((c + 4 - r) % 4) + r]];
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      if (rnd > 0 && rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // n = number of edges up to and including the one after which finish was first seen.
  task automatic wait_finish(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (finish) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b exp=0", finish); end
    total++; if (out !== 128'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    rst = 1'b1;
  endtask

  task automatic test_c1;
    int n;
    din = C1_CT; dkey = C1_KEY; start = 1'b1;
    wait_finish(n);
    total++; if (n != 22) begin bad++; $display("FAIL c1_latency got=%0d exp=21", n - 1); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL c1_out got=%h exp=%h", out, C1_PT); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL c1_hold_finish got=%b exp=1", finish); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL c1_hold_out got=%h exp=%h", out, C1_PT); end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL c1_drop got=%b exp=0", finish); end
  endtask

  task automatic test_appb;
    int n;
    din = B_CT; dkey = B_KEY; start = 1'b1;
    wait_finish(n);
    total++; if (n != 22) begin bad++; $display("FAIL appb_latency got=%0d exp=21", n - 1); end
    total++; if (out !== B_PT) begin bad++; $display("FAIL appb_out got=%h exp=%h", out, B_PT); end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL appb_drop got=%b exp=0", finish); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] cts [2];
    logic [127:0] pts [2];
    int n;
    cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97; pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf; pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    for (int v = 0; v < 2; v++) begin
      din = cts[v]; dkey = B_KEY; start = 1'b1;
      wait_finish(n);
      total++; if (n != 22) begin bad++; $display("FAIL ecb%0d_latency got=%0d exp=21", v, n - 1); end
      total++; if (out !== pts[v]) begin bad++; $display("FAIL ecb%0d_out got=%h exp=%h", v, out, pts[v]); end
      start = 1'b0;
      @(posedge clk); #1;
      total++; if (finish !== 1'b0) begin bad++; $display("FAIL ecb%0d_drop got=%b exp=0", v, finish); end
    end
  endtask

  task automatic test_abort;
    int  n;
    bit  seen;
    din = C1_CT; dkey = C1_KEY; start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (finish) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL abort_finish got=1 exp=0"); end
    total++; if (out !== 128'hae2d8a571e03ac9c9eb76fac45af8e51)
      begin bad++; $display("FAIL abort_out got=%h exp=ae2d8a571e03ac9c9eb76fac45af8e51", out); end
    start = 1'b1;
    wait_finish(n);
    total++; if (n != 22) begin bad++; $display("FAIL abort_retry_latency got=%0d exp=21", n - 1); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL abort_retry_out got=%h exp=%h", out, C1_PT); end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL abort_retry_drop got=%b exp=0", finish); end
  endtask

  task automatic test_reset_mid;
    int n;
    din = C1_CT; dkey = C1_KEY; start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL rstmid_finish got=%b exp=0", finish); end
    total++; if (out !== 128'h0) begin bad++; $display("FAIL rstmid_out got=%h exp=0", out); end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_finish(n);
    total++; if (n != 22) begin bad++; $display("FAIL rstmid_latency got=%0d exp=21", n - 1); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL rstmid_result got=%h exp=%h", out, C1_PT); end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b exp=0", finish); end
  endtask

  task automatic test_input_change;
    int n;
    din = B_CT; dkey = B_KEY; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din  = {$urandom, $urandom, $urandom, $urandom};
    dkey = {$urandom, $urandom, $urandom, $urandom};
    wait_finish(n);
    total++; if (n + 3 != 22) begin bad++; $display("FAIL inchg_latency got=%0d exp=21", n + 2); end
    total++; if (out !== B_PT) begin bad++; $display("FAIL inchg_out got=%h exp=%h", out, B_PT); end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL inchg_drop got=%b exp=0", finish); end
  endtask

  task automatic test_random;
    int n;
    logic [127:0] exp;
    for (int k = 0; k < 6; k++) begin
      din  = {$urandom, $urandom, $urandom, $urandom};
      dkey = {$urandom, $urandom, $urandom, $urandom};
      exp  = model_decrypt(din, dkey);
      start = 1'b1;
      wait_finish(n);
      total++; if (n != 22) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=21", k, n - 1); end
      total++; if (out !== exp) begin bad++; $display("FAIL rand%0d_out got=%h exp=%h", k, out, exp); end
      start = 1'b0;
      @(posedge clk); #1;
      total++; if (finish !== 1'b0) begin bad++; $display("FAIL rand%0d_drop got=%b exp=0", k, finish); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    din   = '0;
    dkey  = '0;
    build_tables();
    test_reset();
    test_c1();
    test_appb();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
